// File: rtl/multi_slave_bridge_if.sv
// rtl/multi_slave_bridge_if.sv - CPU-side and slave-side bus bundle of the multi-slave bridge
interface multi_slave_bridge_if #(
  parameter int N_SLV = 4
);
  logic                   cpu_req;
  logic [31:0]            cpu_addr;
  logic [31:0]            cpu_wdata;
  logic [3:0]             cpu_byteen;
  logic [31:0]            cpu_rdata;
  logic                   cpu_ready;
  logic                   cpu_err;
  logic                   busy;
  logic [N_SLV-1:0]       slv_sel;
  logic [31:0]            slv_addr;
  logic [31:0]            slv_wdata;
  logic [3:0]             slv_byteen;
  logic [N_SLV*32-1:0]    slv_rdata;
  logic [N_SLV-1:0]       slv_ack;

  // master: the bridge, which masters the slave bus and answers the CPU
  modport master (
    input  cpu_req, cpu_addr, cpu_wdata, cpu_byteen, slv_rdata, slv_ack,
    output cpu_rdata, cpu_ready, cpu_err, busy,
           slv_sel, slv_addr, slv_wdata, slv_byteen
  );

  // slave: the surrounding CPU and slave devices
  modport slave (
    output cpu_req, cpu_addr, cpu_wdata, cpu_byteen, slv_rdata, slv_ack,
    input  cpu_rdata, cpu_ready, cpu_err, busy,
           slv_sel, slv_addr, slv_wdata, slv_byteen
  );
endinterface

// File: rtl/multi_slave_bridge.sv
// rtl/multi_slave_bridge.sv - single-outstanding CPU to N-slave address-decoded bridge with ack timeout
module multi_slave_bridge #(
  parameter int                  N_SLV    = 4,
  parameter logic [N_SLV*32-1:0] SLV_BASE = {32'h0000_7F20, 32'h0000_7F10, 32'h0000_7F00, 32'h0000_0000},
  parameter logic [N_SLV*32-1:0] SLV_MASK = {32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_C000},
  parameter int                  TIMEOUT  = 16
) (
  input  logic                clk,
  input  logic                reset,
  multi_slave_bridge_if.master bus
);

  localparam int         IDX_W        = (N_SLV > 1) ? $clog2(N_SLV) : 1;
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t           state;
  logic [7:0]       cnt;
  logic [IDX_W-1:0] idx_q;

  logic             dec_hit;
  logic [IDX_W-1:0] dec_idx;
  logic             sel_ack;
  logic [31:0]      sel_rdata;

  // Scan downwards so the lowest matching index is the one left standing.
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    for (int i = N_SLV - 1; i >= 0; i--) begin
      if ((bus.cpu_addr & SLV_MASK[32*i +: 32]) == (SLV_BASE[32*i +: 32] & SLV_MASK[32*i +: 32])) begin
        dec_hit = 1'b1;
        dec_idx = IDX_W'(i);
      end
    end
  end

  // Only the latched slave's ack and data are ever looked at.
  always_comb begin
    sel_ack   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < N_SLV; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_ack   = bus.slv_ack[i];
        sel_rdata = bus.slv_rdata[32*i +: 32];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      idx_q          <= '0;
      bus.cpu_rdata  <= '0;
      bus.cpu_ready  <= 1'b0;
      bus.cpu_err    <= 1'b0;
      bus.busy       <= 1'b0;
      bus.slv_sel    <= '0;
      bus.slv_addr   <= '0;
      bus.slv_wdata  <= '0;
      bus.slv_byteen <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cpu_req) begin
            bus.slv_addr   <= bus.cpu_addr;
            bus.slv_wdata  <= bus.cpu_wdata;
            bus.slv_byteen <= bus.cpu_byteen;
            idx_q          <= dec_idx;
            bus.busy       <= 1'b1;
            if (dec_hit) begin
              state       <= ACCESS;
              cnt         <= '0;
              bus.slv_sel <= N_SLV'(1) << dec_idx;
            end else begin
              state         <= RESP;
              bus.cpu_ready <= 1'b1;
              bus.cpu_err   <= 1'b1;
              bus.cpu_rdata <= '0;
            end
          end
        end
        ACCESS: begin
          // An ack on the final counted cycle still wins over the timeout.
          if (sel_ack) begin
            state         <= RESP;
            bus.slv_sel   <= '0;
            bus.cpu_ready <= 1'b1;
            bus.cpu_err   <= 1'b0;
            bus.cpu_rdata <= sel_rdata;
          end else if (cnt == TIMEOUT_LAST) begin
            state         <= RESP;
            bus.slv_sel   <= '0;
            bus.cpu_ready <= 1'b1;
            bus.cpu_err   <= 1'b1;
            bus.cpu_rdata <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RESP: begin
          state         <= IDLE;
          bus.cpu_ready <= 1'b0;
          bus.cpu_err   <= 1'b0;
          bus.cpu_rdata <= '0;
          bus.busy      <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          bus.slv_sel <= '0;
          bus.busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multi_slave_bridge.sv
// tb/tb_multi_slave_bridge.sv - randomized self-checking bench for multi_slave_bridge
module tb_multi_slave_bridge;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int errors = 0;
  int checks = 0;
  logic [31:0] last_addr = '0;

  logic [31:0] bases [4] = '{32'h0000_0000, 32'h0000_7F00, 32'h0000_7F10, 32'h0000_7F20};
  logic [31:0] masks [4] = '{32'hFFFF_C000, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FFF0};

  always #5 clk = ~clk;

  multi_slave_bridge_if #(.N_SLV(4)) bus ();

  multi_slave_bridge #(.N_SLV(4), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  function automatic void ref_decode(input logic [31:0] a, output bit hit, output int idx);
    hit = 0;
    idx = 0;
    for (int i = 0; i < 4; i++) begin
      if (!hit && ((a & masks[i]) == (bases[i] & masks[i]))) begin
        hit = 1;
        idx = i;
      end
    end
  endfunction

  // spur: 0 = no foreign acks, 1 = random foreign acks, 2 = every other slave acks every cycle
  task automatic run_txn(input string name, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] be, input int k, input logic [31:0] adata, input int spur);
    bit hit;
    int idx;
    int exp_ready;
    bit exp_err;
    logic [31:0] exp_rdata;
    logic [3:0] oh;
    logic [3:0] exp_sel;
    ref_decode(addr, hit, idx);
    oh = 4'(1 << idx);
    if (!hit) exp_ready = 1;
    else if (k >= 1 && k <= TO) exp_ready = k + 1;
    else exp_ready = TO + 1;
    exp_err = !(hit && k >= 1 && k <= TO);
    exp_rdata = exp_err ? 32'h0 : adata;

    checks++;
    if (bus.busy !== 1'b0 || bus.cpu_ready !== 1'b0 || bus.slv_sel !== 4'b0 || bus.cpu_rdata !== 32'h0) begin
      errors++;
      $display("FAIL %s idle: busy=%b ready=%b sel=%b rdata=%h, required all 0",
               name, bus.busy, bus.cpu_ready, bus.slv_sel, bus.cpu_rdata);
    end
    checks++;
    if (bus.slv_addr !== last_addr) begin
      errors++;
      $display("FAIL %s hold_addr: slv_addr=%h required %h", name, bus.slv_addr, last_addr);
    end

    bus.cpu_req = 1'b1;
    bus.cpu_addr = addr;
    bus.cpu_wdata = wd;
    bus.cpu_byteen = be;
    @(negedge clk);
    for (int c = 1; c <= exp_ready; c++) begin
      exp_sel = (hit && c < exp_ready) ? oh : 4'b0;
      checks++;
      if (bus.slv_sel !== exp_sel) begin
        errors++;
        $display("FAIL %s sel cyc%0d: slv_sel=%b required %b", name, c, bus.slv_sel, exp_sel);
      end
      checks++;
      if (bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL %s busy cyc%0d: busy=%b required 1", name, c, bus.busy);
      end
      checks++;
      if (bus.cpu_ready !== (c == exp_ready)) begin
        errors++;
        $display("FAIL %s ready cyc%0d: cpu_ready=%b required %b", name, c, bus.cpu_ready, (c == exp_ready));
      end
      checks++;
      if (bus.slv_addr !== addr || bus.slv_wdata !== wd || bus.slv_byteen !== be) begin
        errors++;
        $display("FAIL %s latch cyc%0d: addr=%h wdata=%h be=%h required %h %h %h",
                 name, c, bus.slv_addr, bus.slv_wdata, bus.slv_byteen, addr, wd, be);
      end
      checks++;
      if (c == exp_ready) begin
        if (bus.cpu_err !== exp_err || bus.cpu_rdata !== exp_rdata) begin
          errors++;
          $display("FAIL %s resp: err=%b rdata=%h required err=%b rdata=%h",
                   name, bus.cpu_err, bus.cpu_rdata, exp_err, exp_rdata);
        end
      end else begin
        if (bus.cpu_err !== 1'b0 || bus.cpu_rdata !== 32'h0) begin
          errors++;
          $display("FAIL %s quiet cyc%0d: err=%b rdata=%h required 0", name, c, bus.cpu_err, bus.cpu_rdata);
        end
      end

      bus.slv_rdata = {$urandom, $urandom, $urandom, $urandom};
      bus.slv_ack = 4'b0;
      if (c < exp_ready) begin
        if (spur == 1) bus.slv_ack = 4'($urandom) & ~oh;
        if (spur == 2) bus.slv_ack = ~oh;
        if (hit && c == k) begin
          bus.slv_ack = bus.slv_ack | oh;
          bus.slv_rdata[idx*32 +: 32] = adata;
        end
        bus.cpu_req = 1'($urandom);
        bus.cpu_addr = $urandom;
        bus.cpu_wdata = $urandom;
        bus.cpu_byteen = 4'($urandom);
      end else begin
        bus.cpu_req = 1'b0;
      end
      @(negedge clk);
    end
    bus.slv_ack = 4'b0;
    last_addr = addr;
  endtask

  task automatic test_reset();
    checks++;
    if (bus.busy !== 1'b0 || bus.cpu_ready !== 1'b0 || bus.cpu_err !== 1'b0 || bus.cpu_rdata !== 32'h0 ||
        bus.slv_sel !== 4'b0 || bus.slv_addr !== 32'h0 || bus.slv_wdata !== 32'h0 || bus.slv_byteen !== 4'h0) begin
      errors++;
      $display("FAIL reset_state: busy=%b ready=%b err=%b rdata=%h sel=%b addr=%h wdata=%h be=%h required all 0",
               bus.busy, bus.cpu_ready, bus.cpu_err, bus.cpu_rdata, bus.slv_sel,
               bus.slv_addr, bus.slv_wdata, bus.slv_byteen);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    run_txn("read_slv0", 32'h0000_1000, 32'h0, 4'h0, 2, 32'hDEAD_BEEF, 0);
    run_txn("write_slv1", 32'h0000_7F04, 32'h5, 4'hF, 1, 32'h1234_5678, 0);
    run_txn("unmapped", 32'h0000_9000, 32'h0, 4'h0, 1, 32'hAAAA_AAAA, 0);
    run_txn("timeout_slv3", 32'h0000_7F24, 32'h0, 4'h0, 0, 32'h5555_5555, 0);
    run_txn("foreign_ack", 32'h0000_7F08, 32'h0, 4'h0, 4, 32'hCAFE_F00D, 2);
    run_txn("ack_at_limit", 32'h0000_7F14, 32'h0, 4'h0, TO, 32'h0BAD_F00D, 1);
    run_txn("ack_past_limit", 32'h0000_7F18, 32'h0, 4'h0, TO + 1, 32'h7777_7777, 1);
  endtask

  task automatic test_reset_mid();
    bus.cpu_req = 1'b1;
    bus.cpu_addr = 32'h0000_7F04;
    bus.cpu_wdata = 32'h11;
    bus.cpu_byteen = 4'h3;
    @(negedge clk);
    bus.cpu_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.slv_sel !== 4'b0010) begin
      errors++;
      $display("FAIL reset_mid_pre: slv_sel=%b required 0010", bus.slv_sel);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.slv_sel !== 4'b0 || bus.busy !== 1'b0 || bus.slv_addr !== 32'h0 || bus.cpu_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_async: sel=%b busy=%b addr=%h ready=%b required 0",
               bus.slv_sel, bus.busy, bus.slv_addr, bus.cpu_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    last_addr = 32'h0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.cpu_ready !== 1'b0 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_quiet%0d: ready=%b busy=%b required 0", i, bus.cpu_ready, bus.busy);
      end
      @(negedge clk);
    end
    run_txn("after_reset", 32'h0000_7F0C, 32'h99, 4'h1, 3, 32'h0102_0304, 0);
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 4))
        0: a = {18'h0, 14'($urandom)};
        1: a = 32'h0000_7F00 | 32'($urandom_range(0, 15));
        2: a = 32'h0000_7F10 | 32'($urandom_range(0, 15));
        3: a = 32'h0000_7F20 | 32'($urandom_range(0, 15));
        default: a = $urandom;
      endcase
      run_txn("random", a, $urandom, 4'($urandom), $urandom_range(1, TO + 2), $urandom, 1);
    end
  endtask

  initial begin
    bus.cpu_req = 1'b0;
    bus.cpu_addr = '0;
    bus.cpu_wdata = '0;
    bus.cpu_byteen = '0;
    bus.slv_rdata = '0;
    bus.slv_ack = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    test_reset();
    test_directed();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/multi_slave_bridge.md
MULTI_SLAVE_BRIDGE -- requirements
Module: multi_slave_bridge

Interface
REQ-001 The block SHALL have parameter N_SLV, default 4, the number of slave channels (legal range 1..8).
REQ-002 The block SHALL have parameter SLV_BASE, default {32'h0000_7F20, 32'h0000_7F10, 32'h0000_7F00, 32'h0000_0000}, the packed N_SLV*32 base addresses (slave i in bits [32i+31:32i]).
REQ-003 The block SHALL have parameter SLV_MASK, default {32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_C000}, the packed N_SLV*32 match masks.
REQ-004 The block SHALL have parameter TIMEOUT, default 16, the maximum number of cycles spent waiting for a slave acknowledge (legal range 1..255).
REQ-005 The block SHALL have port clk, input, 1, the system clock.
REQ-006 The block SHALL have port reset, input, 1, an asynchronous active-high reset.
REQ-007 The block SHALL have port cpu_req, input, 1, a CPU access request.
REQ-008 The block SHALL have port cpu_addr, input, 32, the CPU byte address.
REQ-009 The block SHALL have port cpu_wdata, input, 32, the CPU write data.
REQ-010 The block SHALL have port cpu_byteen, input, 4, the byte write enables; 4'b0000 denotes a read.
REQ-011 The block SHALL have port cpu_rdata, output, 32, the read data returned to the CPU.
REQ-012 The block SHALL have port cpu_ready, output, 1, a one-cycle response strobe.
REQ-013 The block SHALL have port cpu_err, output, 1, a response error flag, valid together with cpu_ready.
REQ-014 The block SHALL have port busy, output, 1, which is high while a transaction is in flight.
REQ-015 The block SHALL have port slv_sel, output, N_SLV, the one-hot slave select.
REQ-016 The block SHALL have port slv_addr, output, 32, the latched address, broadcast to all slaves.
REQ-017 The block SHALL have port slv_wdata, output, 32, the latched write data, broadcast to all slaves.
REQ-018 The block SHALL have port slv_byteen, output, 4, the latched byte enables, broadcast to all slaves.
REQ-019 The block SHALL have port slv_rdata, input, N_SLV*32, the packed slave read data.
REQ-020 The block SHALL have port slv_ack, input, N_SLV, the per-slave acknowledge.

Function
REQ-021 Slave i SHALL hit when (cpu_addr & SLV_MASK[i]) == (SLV_BASE[i] & SLV_MASK[i]); on multiple hits the lowest index SHALL win.
REQ-022 The block SHALL implement a state machine with states IDLE, ACCESS and RESP.
REQ-023 IDLE: on cpu_req=1 the block SHALL latch addr, wdata, byteen and the decoded index; on a hit it SHALL go to ACCESS, otherwise it SHALL go to RESP with err=1 and rdata=0.
REQ-024 cpu_req SHALL be ignored in ACCESS and RESP; the CPU issues no new request before cpu_ready.
REQ-025 ACCESS: slv_sel SHALL be one-hot on the latched index, and the timeout counter SHALL increment every cycle starting from 0.
REQ-026 ACCESS: slv_ack of the selected slave sampled high SHALL capture its slv_rdata (writes capture it as well; its value is don't-care to the CPU) and move to RESP with err=0.
REQ-027 Acknowledges from unselected slaves SHALL be ignored in every state.
REQ-028 ACCESS: if the counter reaches TIMEOUT-1 without an acknowledge, the next state SHALL be RESP with err=1 and rdata=0; an acknowledge in that same cycle SHALL take precedence (err=0).
REQ-029 RESP: cpu_ready SHALL be 1 for exactly one cycle, with cpu_rdata and cpu_err driven from registers, and the next state SHALL be IDLE.
REQ-030 Outside RESP, cpu_ready, cpu_err and cpu_rdata SHALL be 0.
REQ-031 busy SHALL be 1 in ACCESS and RESP.
REQ-032 slv_sel SHALL be 0 outside ACCESS.
REQ-033 slv_addr, slv_wdata and slv_byteen SHALL hold their latched values until the next request is accepted.
REQ-034 Latency: request accepted at cycle 0, slave acknowledge at cycle k (k>=1) -> cpu_ready at cycle k+1; an unmapped address -> cpu_ready at cycle 1.

Reset
REQ-035 Reset SHALL force IDLE and clear to 0 the counter, cpu_rdata, cpu_ready, cpu_err, busy, slv_sel, slv_addr, slv_wdata and slv_byteen, all asynchronously.
REQ-036 A reset asserted mid-transaction SHALL abort it with no cpu_ready issued, and slv_sel SHALL drop immediately.

Verification
REQ-037 Read 0x0000_1000, slave 0 acks 2 cycles after select with 0xDEAD_BEEF -> slv_sel=4'b0001 for 2 cycles; then cpu_ready=1, cpu_rdata=0xDEAD_BEEF, cpu_err=0.
REQ-038 Write 0x0000_7F04, data 0x5, byteen 4'hF, slave 1 acks immediately -> slv_sel=4'b0010 for 1 cycle, slv_wdata=0x5; cpu_ready the next cycle with cpu_err=0.
REQ-039 Read 0x0000_9000 (unmapped) -> slv_sel stays 0; cpu_ready=1 and cpu_err=1 one cycle after the request; cpu_rdata=0.
REQ-040 Read 0x0000_7F24 with no ack, TIMEOUT=16 -> slv_sel=4'b1000 for exactly 16 cycles; then cpu_ready=1, cpu_err=1.
REQ-041 Slave 2 (unselected) acks while slave 1 is selected -> ignored; the transaction completes only on slave 1's ack, and slave 1's data is returned.
REQ-042 Reset in the 3rd ACCESS cycle -> slv_sel=0 and busy=0 immediately; no cpu_ready; a new request is accepted normally after reset.
